// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: turns rising edges of a slow divided clock into ticks and counts them in BCD
module tick_bcd_counter #(
  parameter int NUM_DIGITS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    slow_clk,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  output logic                    tick,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    wrap
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t                  state, state_n;
  logic [SYNC_STAGES-1:0]  sync;
  logic                    prev;
  logic [4*NUM_DIGITS-1:0] inc;
  logic                    carry;
  logic                    all_nines;
  // slow_clk is sampled as plain data; tick marks the first synchronised high sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], slow_clk};
      prev <= sync[SYNC_STAGES-1];
      tick <= sync[SYNC_STAGES-1] & ~prev;
    end
  // next state: clear beats stop, stop beats start
  always_comb
    state_n = clear ? IDLE : stop ? (state == RUN ? PAUSE : state) : start ? RUN : state;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  assign running = state == RUN;
  // BCD increment: a digit rolls to 0 and carries when it and every lower digit is 9
  always_comb begin
    carry = 1'b1;
    inc   = digits;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      inc[4*i+:4] = carry ? (digits[4*i+:4] == 4'd9 ? 4'd0 : digits[4*i+:4] + 4'd1) : digits[4*i+:4];
      carry       = carry & (digits[4*i+:4] == 4'd9);
    end
    all_nines = carry;
  end
  // count register; ticks only count in RUN (state before this edge) and clear overrides them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      digits <= '0;
      wrap   <= 1'b0;
    end else if (clear) begin
      digits <= '0;
      wrap   <= 1'b0;
    end else if (tick && state == RUN) begin
      digits <= inc;
      wrap   <= all_nines;
    end else begin
      wrap <= 1'b0;
    end
endmodule

// File: tb/tb_tick_bcd_counter.sv
// tb_tick_bcd_counter: directed scoreboard bench for tick_bcd_counter
module tb_tick_bcd_counter;
  localparam int SYNC = 2;
  localparam int MAXV = 9999;
  typedef enum {M_IDLE, M_RUN, M_PAUSE} mst_t;
  logic        clk = 1'b0;
  logic        rst_n, slow_clk, start, stop, clear;
  logic        tick, running, wrap;
  logic [15:0] digits;
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          tick_q[$];
  int          m_count = 0;
  mst_t        m_state = M_IDLE;
  logic        exp_tick = 1'b0;
  logic        exp_wrap = 1'b0;
  logic        last_slow = 1'b0;
  int          n_ticks = 0;
  int          n_wraps = 0;

  tick_bcd_counter #(.NUM_DIGITS(4), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .slow_clk(slow_clk), .start(start), .stop(stop),
    .clear(clear), .tick(tick), .digits(digits), .running(running), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one cycle of inputs, predict the next edge, then compare after it
  task automatic step(input logic s, input logic st, input logic sp, input logic cl);
    logic wn;
    slow_clk = s; start = st; stop = sp; clear = cl;
    if (s && !last_slow) tick_q.push_back(cyc + 1 + SYNC);
    last_slow = s;
    wn = 1'b0;
    if (cl) m_count = 0;
    else if (exp_tick && m_state == M_RUN) begin
      wn = (m_count == MAXV);
      m_count = (m_count + 1) % (MAXV + 1);
    end
    if (cl) m_state = M_IDLE;
    else if (sp) begin
      if (m_state == M_RUN) m_state = M_PAUSE;
    end else if (st) m_state = M_RUN;
    @(posedge clk);
    cyc++;
    #1;
    exp_tick = tick_q.size() > 0 && tick_q[0] == cyc;
    if (exp_tick) void'(tick_q.pop_front());
    exp_wrap = wn;
    n_ticks += int'(tick);
    n_wraps += int'(wrap);
    chk("tick", {15'd0, tick}, {15'd0, exp_tick});
    chk("digits", digits, to_bcd(m_count));
    chk("running", {15'd0, running}, {15'd0, m_state == M_RUN});
    chk("wrap", {15'd0, wrap}, {15'd0, exp_wrap});
  endtask

  task automatic slow_tick(input int h);
    repeat (h) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (h) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // apply control pulses on exactly the edge where the tick would be counted
  task automatic tick_with(input logic st, input logic sp, input logic cl);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 && !exp_tick; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, st, sp, cl);
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; slow_clk = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    // reset held while slow_clk toggles
    for (int i = 0; i < 6; i++) begin
      slow_clk = ~slow_clk;
      @(posedge clk);
      #1;
      chk("rst_tick", {15'd0, tick}, 16'd0);
      chk("rst_digits", digits, 16'h0000);
      chk("rst_running", {15'd0, running}, 16'd0);
      chk("rst_wrap", {15'd0, wrap}, 16'd0);
    end
    slow_clk = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    // 25 slow periods at divisor 4
    step(1'b0, 1'b1, 1'b0, 1'b0);
    n_ticks = 0;
    repeat (25) slow_tick(4);
    chk("t2_tick_count", 16'(n_ticks), 16'd25);
    chk("t2_digits", digits, 16'h0025);
    // pause holds the count, resume continues
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (7) slow_tick(4);
    chk("t4_run7", digits, 16'h0007);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (5) slow_tick(4);
    chk("t4_paused", digits, 16'h0007);
    chk("t4_running", {15'd0, running}, 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) slow_tick(4);
    chk("t4_resumed", digits, 16'h0010);
    // clear coincident with tick, then stop coincident with tick
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (42) slow_tick(3);
    chk("t5_pre", digits, 16'h0042);
    n_wraps = 0;
    tick_with(1'b0, 1'b0, 1'b1);
    chk("t5_clear_digits", digits, 16'h0000);
    chk("t5_clear_running", {15'd0, running}, 16'd0);
    chk("t5_no_wrap", 16'(n_wraps), 16'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    tick_with(1'b0, 1'b1, 1'b0);
    chk("t5_stop_counted", digits, 16'h0001);
    chk("t5_stop_paused", {15'd0, running}, 16'd0);
    // run up to 9999 and wrap
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (MAXV) slow_tick(3);
    chk("t3_full", digits, 16'h9999);
    n_wraps = 0;
    slow_tick(3);
    chk("t3_wrap_pulses", 16'(n_wraps), 16'd1);
    chk("t3_wrapped", digits, 16'h0000);
    chk("t3_still_running", {15'd0, running}, 16'd1);
    // async reset between tick and the digit update
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (123) slow_tick(3);
    chk("t6_pre", digits, 16'h0123);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8 && !exp_tick; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_tick_pending", {15'd0, tick}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_digits", digits, 16'h0000);
    chk("t6_async_running", {15'd0, running}, 16'd0);
    chk("t6_async_tick", {15'd0, tick}, 16'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("t6_hold_digits", digits, 16'h0000);
    end
    slow_clk = 1'b0;
    rst_n = 1'b1;
    m_count = 0; m_state = M_IDLE; exp_tick = 1'b0; exp_wrap = 1'b0; last_slow = 1'b0;
    tick_q.delete();
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_no_late_inc", digits, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    slow_tick(3);
    chk("t6_recount", digits, 16'h0001);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
